// File: rtl/motion_pkg.sv
// Shared definitions for the motion sequencer: command/state encodings,
// direction-pin patterns and default timing values.
package motion_pkg;

   // Default timing at a 100 MHz clock: 60 Hz PWM, 1 ms dead-time.
   localparam int unsigned PWM_PERIOD_DEF = 1666667;
   localparam int unsigned DEAD_TICKS_DEF = 100000;
   localparam int unsigned RAMP_STEP_DEF  = 104167;

   // Width of the PWM counter and duty field, and of the duration counter.
   localparam int CNT_W = 21;
   localparam int DUR_W = 32;

   // Command opcodes. OP_STOP doubles as "no direction" for the last-run tracker.
   typedef enum logic [1:0] {
      OP_STOP   = 2'd0,
      OP_FWD    = 2'd1,
      OP_TURN_L = 2'd2,
      OP_TURN_R = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DEAD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_FAULT = 2'd3
   } state_e;

   // Direction pins ordered {IN1, IN2, IN3, IN4} =
   // {right-fwd, right-back, left-fwd, left-back}.
   localparam logic [3:0] IN_OFF    = 4'b0000;
   localparam logic [3:0] IN_FWD    = 4'b1010;
   localparam logic [3:0] IN_TURN_R = 4'b0110;
   localparam logic [3:0] IN_TURN_L = 4'b1001;

   function automatic logic [3:0] in_pattern(input op_e op);
      logic [3:0] pat;
      case (op)
         OP_FWD:    pat = IN_FWD;
         OP_TURN_R: pat = IN_TURN_R;
         OP_TURN_L: pat = IN_TURN_L;
         default:   pat = IN_OFF;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/pwm_gen.sv
// Shared PWM generator for both motor channels: one period counter, a duty
// compare with saturation, zero-latency overcurrent gating and, when
// MOTION_SEQ_SOFT_START_EN is defined, a per-period soft-start ramp.
module pwm_gen
   import motion_pkg::*;
#(
   parameter int unsigned PWM_PERIOD = PWM_PERIOD_DEF,
   parameter int unsigned RAMP_STEP  = RAMP_STEP_DEF
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [CNT_W-1:0] duty_i,
   input  logic             oc_i,
   output logic [1:0]       pwm_o
);

`ifdef MOTION_SEQ_SOFT_START_EN
   localparam bit SOFT_START = 1'b1;
`else
   localparam bit SOFT_START = 1'b0;
`endif
   // A zero step could never rise, so it behaves like no ramp at all.
   localparam bit RAMP_EN = SOFT_START && (RAMP_STEP != 0);

   localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PWM_PERIOD);
   localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(PWM_PERIOD - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] duty_sat;
   logic [CNT_W-1:0] duty_eff;
   logic             wrap;
   logic             pwm_on;

   assign wrap = (cnt_q == LAST_C);

   // Counter is held at zero outside RUN so every run starts a fresh period.
   always_comb begin
      cnt_d = '0;
      if (en_i && !wrap) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Period counter register.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Duties at or above the period mean always-on.
   assign duty_sat = (duty_i >= PERIOD_C) ? PERIOD_C : duty_i;

   generate
      if (RAMP_EN) begin : g_ramp
         localparam logic [CNT_W:0] STEP_C = (CNT_W+1)'(RAMP_STEP);

         logic [CNT_W-1:0] ramp_q, ramp_d;
         logic [CNT_W:0]   ramp_sum;

         assign ramp_sum = {1'b0, ramp_q} + STEP_C;

         // Ramp restarts from zero each run and steps once per period wrap.
         always_comb begin
            ramp_d = ramp_q;
            if (!en_i) begin
               ramp_d = '0;
            end else if (wrap) begin
               ramp_d = (ramp_sum >= {1'b0, duty_sat}) ? duty_sat : ramp_sum[CNT_W-1:0];
            end
         end

         // Ramp level register.
         always_ff @(posedge clock or negedge rst_n) begin
            if (!rst_n) begin
               ramp_q <= '0;
            end else begin
               ramp_q <= ramp_d;
            end
         end

         assign duty_eff = ramp_q;
      end else begin : g_flat
         assign duty_eff = duty_sat;
      end
   endgenerate

   // Overcurrent masks the output combinationally, without waiting a cycle.
   assign pwm_on = en_i && (cnt_q < duty_eff) && !oc_i;

   for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      assign pwm_o[gi] = pwm_on;
   end

endmodule

// File: rtl/motion_sequencer.sv
// Two-motor command sequencer: accepts STOP/FWD/TURN commands, inserts a
// dead-time on direction reversal, runs the PWM for a timed duration and
// latches overcurrent faults. Optional soft-start ramp is enabled with
// MOTION_SEQ_SOFT_START_EN (implemented inside pwm_gen).
module motion_sequencer
   import motion_pkg::*;
#(
   parameter int unsigned PWM_PERIOD = PWM_PERIOD_DEF,
   parameter int unsigned DEAD_TICKS = DEAD_TICKS_DEF,
   parameter int unsigned RAMP_STEP  = RAMP_STEP_DEF
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_duty,
   input  logic [DUR_W-1:0] cmd_dur,
   input  logic             abort,
   input  logic             oc,
   input  logic             fault_clr,
   output logic             IN1,
   output logic             IN2,
   output logic             IN3,
   output logic             IN4,
   output logic             PWMA,
   output logic             PWMB,
   output logic             busy,
   output logic             done,
   output logic             fault
);

   localparam logic [DUR_W-1:0] DEAD_LAST = DUR_W'(DEAD_TICKS - 1);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   op_e              dir_q, dir_d;      // last run direction, OP_STOP = none
   logic [CNT_W-1:0] duty_q, duty_d;
   logic [DUR_W-1:0] dur_q, dur_d;      // always >= 1 once latched
   logic [DUR_W-1:0] dead_q, dead_d;
   logic [DUR_W-1:0] run_q, run_d;
   logic             done_q, done_d;

   logic             accept;
   op_e              new_op;
   logic [3:0]       in_pat;
   logic [1:0]       pwm;

   assign cmd_ready = (state_q == ST_IDLE) && !oc;
   assign accept    = cmd_valid && cmd_ready;
   assign new_op    = op_e'(cmd_op);

   // Next-state logic: overcurrent beats abort, abort beats completion.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      dir_d   = dir_q;
      duty_d  = duty_q;
      dur_d   = dur_q;
      dead_d  = dead_q;
      run_d   = run_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d   = new_op;
               duty_d = cmd_duty;
               dur_d  = (cmd_dur == '0) ? DUR_W'(1) : cmd_dur;
               dead_d = '0;
               run_d  = '0;
               if (new_op == OP_STOP) begin
                  done_d = 1'b1;
               end else begin
                  dir_d = new_op;
                  if ((new_op != dir_q) && (DEAD_TICKS != 0)) begin
                     state_d = ST_DEAD;
                  end else begin
                     state_d = ST_RUN;
                  end
               end
            end
         end
         ST_DEAD: begin
            if (oc) begin
               state_d = ST_FAULT;
            end else if (abort) begin
               state_d = ST_IDLE;
            end else if (dead_q == DEAD_LAST) begin
               state_d = ST_RUN;
               run_d   = '0;
            end else begin
               dead_d = dead_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (oc) begin
               state_d = ST_FAULT;
            end else if (abort) begin
               state_d = ST_IDLE;
            end else if (run_q == dur_q - 1'b1) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               run_d = run_q + 1'b1;
            end
         end
         ST_FAULT: begin
            if (fault_clr && !oc) begin
               state_d = ST_IDLE;
               dir_d   = OP_STOP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and latched-command registers.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= OP_STOP;
         dir_q   <= OP_STOP;
         duty_q  <= '0;
         dur_q   <= '0;
         dead_q  <= '0;
         run_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         dir_q   <= dir_d;
         duty_q  <= duty_d;
         dur_q   <= dur_d;
         dead_q  <= dead_d;
         run_q   <= run_d;
         done_q  <= done_d;
      end
   end

   // Bridge drive only while running; everything is released otherwise.
   assign in_pat               = (state_q == ST_RUN) ? in_pattern(op_q) : IN_OFF;
   assign {IN1, IN2, IN3, IN4} = in_pat;

   assign busy  = (state_q == ST_DEAD) || (state_q == ST_RUN);
   assign fault = (state_q == ST_FAULT);
   assign done  = done_q;

   pwm_gen #(
      .PWM_PERIOD (PWM_PERIOD),
      .RAMP_STEP  (RAMP_STEP)
   ) u_pwm (
      .clock  (clock),
      .rst_n  (rst_n),
      .en_i   (state_q == ST_RUN),
      .duty_i (duty_q),
      .oc_i   (oc),
      .pwm_o  (pwm)
   );

   assign PWMA = pwm[0];
   assign PWMB = pwm[1];

endmodule
